// File: rtl/line_burst_arbiter.sv
// line_burst_arbiter: round-robin sharing of one 64-bit burst memory port between I- and D-cache 256-bit line transfers.
module line_burst_arbiter #(
  parameter int BEATS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_mem_read,
  input  logic                i_mem_write,
  input  logic [31:0]         i_mem_address,
  input  logic [64*BEATS-1:0] i_mem_wdata,
  output logic [64*BEATS-1:0] i_mem_rdata,
  output logic                i_mem_resp,
  input  logic                d_mem_read,
  input  logic                d_mem_write,
  input  logic [31:0]         d_mem_address,
  input  logic [64*BEATS-1:0] d_mem_wdata,
  output logic [64*BEATS-1:0] d_mem_rdata,
  output logic                d_mem_resp,
  output logic                burst_read,
  output logic                burst_write,
  output logic [31:0]         burst_address,
  output logic [63:0]         burst_wdata,
  input  logic [63:0]         burst_rdata,
  input  logic                burst_resp
);
  localparam int LW = 64 * BEATS;
  localparam int BW = $clog2(BEATS);
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
  state_e          state_q;
  logic            grant_q;
  logic [BW-1:0]   beat_q;
  logic [31:0]     addr_q;
  logic [LW-1:0]   line_q;
  logic            wr_q;
  logic            i_req, d_req, pick_d, sel_wr, last_beat, done;
  assign i_req     = i_mem_read | i_mem_write;
  assign d_req     = d_mem_read | d_mem_write;
  // grant_q doubles as last_grant: it only changes at a grant, so ties go to the other client
  assign pick_d    = d_req & (~i_req | ~grant_q);
  assign sel_wr    = pick_d ? d_mem_write : i_mem_write;
  assign last_beat = beat_q == BW'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      beat_q  <= '0;
      addr_q  <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (i_req | d_req) begin
          grant_q <= pick_d;
          addr_q  <= (pick_d ? d_mem_address : i_mem_address) & ~32'h1f;
          if (sel_wr) line_q <= pick_d ? d_mem_wdata : i_mem_wdata;
          wr_q    <= sel_wr;
          beat_q  <= '0;
          state_q <= sel_wr ? WRITE : READ;
        end
        READ: if (burst_resp) begin
          line_q[64*beat_q +: 64] <= burst_rdata;
          beat_q <= beat_q + 1'b1;
          if (last_beat) state_q <= DONE;
        end
        WRITE: if (burst_resp) begin
          beat_q <= beat_q + 1'b1;
          if (last_beat) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign done          = state_q == DONE;
  assign burst_read    = state_q == READ;
  assign burst_write   = state_q == WRITE;
  assign burst_address = addr_q;
  assign burst_wdata   = burst_write ? line_q[64*beat_q +: 64] : 64'h0;
  assign i_mem_resp    = done & ~grant_q;
  assign d_mem_resp    = done & grant_q;
  assign i_mem_rdata   = (i_mem_resp & ~wr_q) ? line_q : '0;
  assign d_mem_rdata   = (d_mem_resp & ~wr_q) ? line_q : '0;
endmodule

// File: tb/tb_line_burst_arbiter.sv
// tb_line_burst_arbiter: scoreboard bench driving cache requests and a scripted burst memory.
module tb_line_burst_arbiter;
  logic clk = 0, rst = 0;
  logic i_mem_read = 0, i_mem_write = 0, d_mem_read = 0, d_mem_write = 0;
  logic [31:0] i_mem_address = 0, d_mem_address = 0;
  logic [255:0] i_mem_wdata = 0, d_mem_wdata = 0, i_mem_rdata, d_mem_rdata;
  logic i_mem_resp, d_mem_resp, burst_read, burst_write, burst_resp = 0;
  logic [31:0] burst_address;
  logic [63:0] burst_wdata, burst_rdata = 0;
  int checks = 0, failures = 0;
  typedef struct packed {logic cli; logic [255:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t e;

  line_burst_arbiter dut (
    .clk(clk), .rst(rst),
    .i_mem_read(i_mem_read), .i_mem_write(i_mem_write), .i_mem_address(i_mem_address),
    .i_mem_wdata(i_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_resp(i_mem_resp),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write), .d_mem_address(d_mem_address),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_resp(d_mem_resp),
    .burst_read(burst_read), .burst_write(burst_write), .burst_address(burst_address),
    .burst_wdata(burst_wdata), .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scripted memory: waits for a burst, then serves 4 beats with 'stall' idle cycles before each
  task automatic mem_burst(input int stall, input logic [255:0] rline, output logic [255:0] wline,
                           output logic [31:0] addr, output logic was_wr, output int lat, output logic stable);
    logic [63:0] wd;
    wline = '0; addr = '0; was_wr = 0; stable = 1; lat = 0;
    do begin step(); lat++; end while (!(burst_read || burst_write) && lat < 20);
    if (!(burst_read || burst_write)) begin stable = 0; return; end
    addr = burst_address; was_wr = burst_write;
    for (int b = 0; b < 4; b++) begin
      wd = burst_wdata;
      for (int s = 0; s < stall; s++) begin
        burst_resp = 0;
        step();
        if (burst_address !== addr || burst_write !== was_wr || burst_read !== !was_wr || burst_wdata !== wd) stable = 0;
      end
      burst_resp = 1; burst_rdata = rline[64*b +: 64]; wline[64*b +: 64] = wd;
      step();
      burst_resp = 0; burst_rdata = '0;
      if (b < 3 && (burst_address !== addr || burst_write !== was_wr || burst_read !== !was_wr)) stable = 0;
    end
  endtask

  task automatic test_reset();
    rst = 0;
    step(); step();
    checks++; if ({burst_read, burst_write} !== 2'b00) begin failures++; $display("FAIL reset_burst_rw got %b want 00", {burst_read, burst_write}); end
    checks++; if (burst_address !== 32'h0) begin failures++; $display("FAIL reset_address got %h want 0", burst_address); end
    checks++; if (burst_wdata !== 64'h0) begin failures++; $display("FAIL reset_wdata got %h want 0", burst_wdata); end
    checks++; if ({i_mem_resp, d_mem_resp} !== 2'b00 || i_mem_rdata !== '0 || d_mem_rdata !== '0) begin
      failures++; $display("FAIL reset_client got resp=%b%b want 00 and rdata 0", i_mem_resp, d_mem_resp); end
    rst = 1;
    step();
  endtask

  task automatic test_single_read();
    logic [255:0] rl, wl; logic [31:0] a; logic w, st; int lat;
    rl = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
    i_mem_read = 1; i_mem_address = 32'h0000_1234;
    exp_q.push_back('{cli: 1'b0, data: rl});
    mem_burst(0, rl, wl, a, w, lat, st);
    checks++; if (lat !== 1) begin failures++; $display("FAIL read_latency got %0d want 1", lat); end
    checks++; if (a !== 32'h0000_1220) begin failures++; $display("FAIL read_address got %h want 00001220", a); end
    checks++; if (w !== 1'b0 || st !== 1'b1) begin failures++; $display("FAIL read_burst got wr=%b stable=%b want 0 1", w, st); end
    checks++; if ({i_mem_resp, d_mem_resp} !== 2'b10) begin failures++; $display("FAIL read_resp got %b%b want 10", i_mem_resp, d_mem_resp); end
    e = exp_q.pop_front();
    checks++; if (i_mem_rdata !== e.data) begin failures++; $display("FAIL read_rdata got %h want %h", i_mem_rdata, e.data); end
    i_mem_read = 0;
    step();
    checks++; if (i_mem_resp !== 1'b0 || i_mem_rdata !== '0 || d_mem_resp !== 1'b0) begin
      failures++; $display("FAIL read_resp_pulse got resp=%b rdata=%h want 0 0", i_mem_resp, i_mem_rdata); end
  endtask

  task automatic test_write_stall();
    logic [255:0] wl; logic [31:0] a; logic w, st; int lat;
    d_mem_write = 1; d_mem_address = 32'h8000_00ff;
    d_mem_wdata = {64'hD3D3D3D3D3D3D3D3, 64'hD2D2D2D2D2D2D2D2, 64'hD1D1D1D1D1D1D1D1, 64'hD0D0D0D0D0D0D0D0};
    exp_q.push_back('{cli: 1'b1, data: '0});
    mem_burst(2, '0, wl, a, w, lat, st);
    checks++; if (w !== 1'b1 || a !== 32'h8000_00e0) begin failures++; $display("FAIL write_burst got wr=%b addr=%h want 1 800000e0", w, a); end
    checks++; if (wl !== d_mem_wdata) begin failures++; $display("FAIL write_beats got %h want %h", wl, d_mem_wdata); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL write_stall_hold got %b want 1", st); end
    e = exp_q.pop_front();
    checks++; if ({i_mem_resp, d_mem_resp} !== {~e.cli, e.cli} || d_mem_rdata !== e.data) begin
      failures++; $display("FAIL write_resp got %b%b rdata=%h want 01 0", i_mem_resp, d_mem_resp, d_mem_rdata); end
    d_mem_write = 0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [255:0] rl, wl; logic [31:0] a; logic w, st; int lat; logic last;
    rst = 0; step(); rst = 1;
    last = 0;
    i_mem_read = 1; i_mem_address = 32'h0000_2040;
    d_mem_read = 1; d_mem_address = 32'h0000_3068;
    for (int t = 0; t < 4; t++) begin
      rl = {8{32'hC0DE_0000 | 32'(t)}};
      last = ~last;
      exp_q.push_back('{cli: last, data: rl});
      mem_burst(0, rl, wl, a, w, lat, st);
      checks++; if (a !== (last ? 32'h0000_3060 : 32'h0000_2040) || lat !== 1) begin
        failures++; $display("FAIL rr_address t=%0d got %h lat=%0d want %h 1", t, a, lat, last ? 32'h3060 : 32'h2040); end
      e = exp_q.pop_front();
      checks++; if ({d_mem_resp, i_mem_resp} !== {e.cli, ~e.cli} || (e.cli ? d_mem_rdata : i_mem_rdata) !== e.data) begin
        failures++; $display("FAIL rr_order t=%0d got d=%b i=%b want d=%b", t, d_mem_resp, i_mem_resp, e.cli); end
      if (t == 3) begin i_mem_read = 0; d_mem_read = 0; end
      else if (last) d_mem_read = 0; else i_mem_read = 0;
      step();
      i_mem_read = (t < 3); d_mem_read = (t < 3);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] rl, wl; logic [31:0] a; logic w, st; int lat;
    i_mem_read = 1; i_mem_address = 32'h0000_4444;
    lat = 0;
    do begin step(); lat++; end while (!burst_read && lat < 20);
    checks++; if (burst_read !== 1'b1) begin failures++; $display("FAIL mid_start got %b want 1", burst_read); end
    for (int b = 0; b < 2; b++) begin
      burst_resp = 1; burst_rdata = 64'hBAD0_0000_0000_0000 | 64'(b);
      step();
    end
    burst_resp = 0; rst = 0;
    step();
    checks++; if ({burst_read, burst_write, i_mem_resp, d_mem_resp} !== 4'b0 || burst_address !== 32'h0) begin
      failures++; $display("FAIL mid_reset_outputs got rw=%b%b resp=%b addr=%h want 0", burst_read, burst_write, i_mem_resp, burst_address); end
    rst = 1;
    rl = {4{64'h5A5A_0000_1234_0000}};
    exp_q.push_back('{cli: 1'b0, data: rl});
    mem_burst(0, rl, wl, a, w, lat, st);
    checks++; if (lat !== 1 || a !== 32'h0000_4440) begin failures++; $display("FAIL mid_fresh_start got lat=%0d addr=%h want 1 00004440", lat, a); end
    e = exp_q.pop_front();
    checks++; if (i_mem_resp !== 1'b1 || i_mem_rdata !== e.data) begin
      failures++; $display("FAIL mid_fresh_rdata got resp=%b %h want 1 %h", i_mem_resp, i_mem_rdata, e.data); end
    i_mem_read = 0;
    step();
  endtask

  task automatic test_rw_both();
    logic [255:0] wl; logic [31:0] a; logic w, st; int lat; logic quiet;
    quiet = 1;
    for (int c = 0; c < 3; c++) begin
      burst_resp = 1; step();
      if ({burst_read, burst_write, i_mem_resp, d_mem_resp} !== 4'b0) quiet = 0;
    end
    burst_resp = 0;
    checks++; if (quiet !== 1'b1) begin failures++; $display("FAIL idle_resp_ignored got %b want 1", quiet); end
    i_mem_read = 1; i_mem_write = 1; i_mem_address = 32'h0000_5000;
    i_mem_wdata = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    exp_q.push_back('{cli: 1'b0, data: '0});
    mem_burst(1, {4{64'hFFFF}}, wl, a, w, lat, st);
    checks++; if (w !== 1'b1 || wl !== i_mem_wdata || st !== 1'b1) begin
      failures++; $display("FAIL rw_write got wr=%b data=%h want 1 %h", w, wl, i_mem_wdata); end
    e = exp_q.pop_front();
    checks++; if (i_mem_resp !== 1'b1 || i_mem_rdata !== e.data) begin
      failures++; $display("FAIL rw_resp got resp=%b rdata=%h want 1 0", i_mem_resp, i_mem_rdata); end
    i_mem_read = 0; i_mem_write = 0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_stall();
    test_back_to_back();
    test_reset_mid_burst();
    test_rw_both();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
